// File: rtl/uart_rx_frame_control_module.sv
`timescale 1ns/1ps
// uart_rx_frame_control_module
//
// Receive-side frame controller for the fixed 7-byte Modbus link. It sits
// behind the UART receiver and does the following:
//   - assembles the byte stream into one frame;
//   - checks the slave address (own address or broadcast 8'h00);
//   - checks the Modbus CRC16 over bytes 0-4 against bytes 5 (low) and 6 (high);
//   - enforces inter-frame silence.
// A good frame is presented in parallel together with a one-cycle done pulse.
// A rejected frame produces a one-cycle error pulse and an error code.
//
// Parameters
//   SLAVE_ADDR      this node's address
//   T_GAP           silence length in CLK cycles (>= 2)
// Ports
//   CLK             system clock, rising edge
//   RSTn            asynchronous active-low reset
//   RX_Done_Sig     one-cycle pulse per received byte
//   RX_Data[7:0]    received byte, valid while RX_Done_Sig is high
//   Frame_Done_Sig  one-cycle pulse, Frame_Data holds a new good frame
//   Frame_Err_Sig   one-cycle pulse, frame rejected
//   Err_Code[1:0]   last rejection: 01 timeout, 10 CRC, 11 address
//   Frame_Data[55:0] last good frame, byte0 at [55:48], byte6 at [7:0]
//   RX_Busy_Sig     high whenever the controller is not idle
module uart_rx_frame_control_module #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h01,
    parameter logic [19:0] T_GAP      = 20'd200_000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RX_Done_Sig,
    input  logic [7:0]  RX_Data,
    output logic        Frame_Done_Sig,
    output logic        Frame_Err_Sig,
    output logic [1:0]  Err_Code,
    output logic [55:0] Frame_Data,
    output logic        RX_Busy_Sig
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [19:0] GAP_LAST = T_GAP - 20'd1;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [19:0]  timer_q, timer_d;
    logic [15:0]  crc_q, crc_d;
    logic [7:0]   byte_buf_q [7];
    logic [7:0]   byte_buf_d [7];
    logic [55:0]  buf_flat;
    logic [55:0]  frame_data_q, frame_data_d;
    logic [1:0]   err_code_q, err_code_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         shift_en;
    logic         timer_last;
    logic         addr_ok;
    logic         crc_ok;

    // One byte of Modbus CRC16 (reflected poly A001), all 8 bit steps unrolled.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign timer_last = (timer_q == GAP_LAST);
    assign addr_ok    = (byte_buf_q[0] == SLAVE_ADDR) || (byte_buf_q[0] == 8'h00);
    assign crc_ok     = ({byte_buf_q[6], byte_buf_q[5]} == crc_q);

    // Bytes are only taken while a frame is still being collected. Once the
    // counter holds 7, further bytes are dropped until the gap has elapsed.
    assign shift_en = RX_Done_Sig &&
                      ((state_q == ST_IDLE) || ((state_q == ST_RECV) && (cnt_q != 3'd7)));

    // Shift buffer: new bytes enter at slot 6, so byte0 ends up in slot 0
    // after seven shifts.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_buf
            if (gi < 6) begin : g_mid
                assign byte_buf_d[gi] = shift_en ? byte_buf_q[gi+1] : byte_buf_q[gi];
            end else begin : g_tail
                assign byte_buf_d[gi] = shift_en ? RX_Data : byte_buf_q[gi];
            end
            assign buf_flat[55-8*gi -: 8] = byte_buf_q[gi];
        end
    endgenerate

    // State register and all datapath flops.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            timer_q      <= 20'd0;
            crc_q        <= 16'hFFFF;
            frame_data_q <= 56'h0;
            err_code_q   <= 2'b00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                byte_buf_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            crc_q        <= crc_d;
            frame_data_q <= frame_data_d;
            err_code_q   <= err_code_d;
            done_q       <= done_d;
            err_q        <= err_d;
            for (int i = 0; i < 7; i++) begin
                byte_buf_q[i] <= byte_buf_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (RX_Done_Sig) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                // A byte arriving in the timeout cycle keeps the frame alive.
                if (cnt_q == 3'd7) begin
                    state_d = ST_CHECK;
                end else if (!RX_Done_Sig && timer_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (!RX_Done_Sig && timer_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and pulse generation.
    always_comb begin
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        crc_d        = crc_q;
        frame_data_d = frame_data_q;
        err_code_d   = err_code_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = 3'd0;
                timer_d = 20'd0;
                crc_d   = 16'hFFFF;
                if (RX_Done_Sig) begin
                    crc_d = crc16_byte(16'hFFFF, RX_Data);
                    cnt_d = 3'd1;
                end
            end
            ST_RECV: begin
                if (cnt_q != 3'd7) begin
                    if (RX_Done_Sig) begin
                        // Bytes 5 and 6 carry the CRC itself and are not hashed.
                        if (cnt_q < 3'd5) begin
                            crc_d = crc16_byte(crc_q, RX_Data);
                        end
                        cnt_d   = cnt_q + 3'd1;
                        timer_d = 20'd0;
                    end else if (timer_last) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        cnt_d      = 3'd0;
                        timer_d    = 20'd0;
                        crc_d      = 16'hFFFF;
                    end else begin
                        timer_d = timer_q + 20'd1;
                    end
                end
            end
            ST_CHECK: begin
                cnt_d   = 3'd0;
                timer_d = 20'd0;
                crc_d   = 16'hFFFF;
                if (!addr_ok) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else if (!crc_ok) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    done_d       = 1'b1;
                    frame_data_d = buf_flat;
                end
            end
            ST_GAP: begin
                // Any byte during the gap restarts the silence window.
                if (RX_Done_Sig || timer_last) begin
                    timer_d = 20'd0;
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
            default: begin
                cnt_d   = 3'd0;
                timer_d = 20'd0;
                crc_d   = 16'hFFFF;
            end
        endcase
    end

    assign Frame_Done_Sig = done_q;
    assign Frame_Err_Sig  = err_q;
    assign Err_Code       = err_code_q;
    assign Frame_Data     = frame_data_q;
    assign RX_Busy_Sig    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_frame_control_module.md
# uart_rx_frame_control_module

- Receive-side frame controller for the fixed 7-byte Modbus link; the transmit-side controller feeds the UART transmitter, and this block sits after the UART receiver.
- Collects the byte stream into one frame, checks the slave address and the Modbus CRC16, and enforces inter-frame silence.
- Presents each validated frame in parallel with a one-cycle done pulse; bad frames produce a one-cycle error pulse with a code.

## Interface
- `SLAVE_ADDR`, default 8'h01: this node's address. Address 8'h00 (broadcast) is also accepted.
- `T_GAP`, default 20'd200_000: silence length in CLK cycles, ≈3.5 characters at 9600 baud on a 50 MHz clock. Must be ≥ 2.
- `CLK` in 1: system clock, rising-edge.
- `RSTn` in 1: asynchronous, active-low reset.
- `RX_Done_Sig` in 1: one-cycle pulse from the UART receiver, one per received byte.
- `RX_Data` in 8: received byte; valid in the cycle `RX_Done_Sig` is high.
- `Frame_Done_Sig` out 1: one-cycle pulse when a valid frame is available.
- `Frame_Err_Sig` out 1: one-cycle pulse when a frame is rejected.
- `Err_Code` out 2: reason for the last rejection. 01 = short frame (timeout), 10 = CRC mismatch, 11 = address mismatch.
- `Frame_Data` out 56: last valid frame. Byte0 is at [55:48] and byte6 is at [7:0].
- `RX_Busy_Sig` out 1: high whenever the state is not IDLE.

## Operation
- **Frame layout:**
  - byte0 = address
  - byte1 = function
  - bytes 2–4 = data
  - byte5 = CRC low byte
  - byte6 = CRC high byte
- **CRC:** Modbus CRC16 over bytes 0–4.
  - Initial value 16'hFFFF, reflected polynomial 16'hA001.
  - Computed byte-wise, 8 iterations unrolled, updated in the same cycle the byte is sampled.
- **Storage:** a 7×8 shift buffer, a 3-bit byte counter (0–7), a 20-bit gap timer and a 16-bit CRC register.
- **IDLE:** counter = 0, CRC = FFFF, timer = 0.
  - `RX_Done_Sig` stores byte0, updates CRC, sets counter = 1, clears timer, then goes to RECV.
- **RECV:** the timer increments every cycle without `RX_Done_Sig`.
  - On `RX_Done_Sig`: store the byte, update CRC only when counter < 5, increment counter, clear timer.
  - When counter reaches 7, go to CHECK.
  - If the timer reaches T_GAP−1 with no byte: pulse `Frame_Err_Sig`, set `Err_Code` = 01, go to IDLE.
  - If `RX_Done_Sig` arrives in the same cycle as the timeout, the byte wins: it is accepted and no error is raised.
- **CHECK** (1 cycle), with checks in priority order:
  1. byte0 ≠ `SLAVE_ADDR` and byte0 ≠ 00: error, code 11.
  2. {byte6, byte5} ≠ CRC: error, code 10.
  3. Otherwise: `Frame_Data` ← buffer and `Frame_Done_Sig` pulses.
  - In all three cases the next state is GAP.
- **GAP:** the timer counts; any `RX_Done_Sig` clears the timer and the byte is discarded silently. After T_GAP idle cycles, go to IDLE.
- **Output hold:** `Frame_Data` and `Err_Code` hold their values until overwritten by the next good frame or the next error respectively.
- **Pulse exclusivity:** `Frame_Done_Sig` and `Frame_Err_Sig` are never high together.
- **Reset (asynchronous, including mid-frame):**
  - state = IDLE; counter, timer and buffer = 0; CRC = FFFF.
  - All outputs = 0 (`Frame_Data` = 56'h0, `Err_Code` = 00, pulses low, `RX_Busy_Sig` low).
  - The partial frame is discarded and no pulse is emitted.

## Timing
- Edge E samples the 7th `RX_Done_Sig`; the state is CHECK in the cycle after E.
- `Frame_Done_Sig` or `Frame_Err_Sig` is high for exactly the cycle after CHECK, i.e. two edges after E.
- `Frame_Data` updates on the same edge that raises `Frame_Done_Sig`.
- Timeout: with the last byte sampled at edge E, `Frame_Err_Sig` is high in the cycle beginning at edge E+T_GAP.
- `RX_Busy_Sig` rises on the edge that samples byte0 and falls on the edge of the return to IDLE.
- `RX_Done_Sig` pulses closer than 1 cycle apart are not supported. Back-to-back pulses on consecutive cycles must be accepted.

## Test plan
- **Valid frame** (T_GAP=100): bytes 01 03 02 00 0A 38 43, 20 cycles apart.
  - Required: one `Frame_Done_Sig` pulse; `Frame_Data` = 56'h010302000A3843; no error pulse.
  - After 100 idle cycles the block returns to IDLE and `RX_Busy_Sig` = 0.
- **CRC error:** same frame with last byte 44.
  - Required: `Frame_Err_Sig` pulse, `Err_Code` = 10, `Frame_Data` unchanged from the previous good frame.
- **Address mismatch:** bytes 02 03 02 00 0A 38 43.
  - Required: `Err_Code` = 11 (address priority over CRC).
  - The same bytes with byte0 = 00 and a bench-model CRC must give `Frame_Done_Sig`.
- **Short frame:** 3 bytes 01 03 02, then silence.
  - Required: `Frame_Err_Sig` exactly 100 cycles after the edge sampling the 3rd byte, `Err_Code` = 01, state IDLE.
  - A following valid frame is accepted.
- **Gap enforcement and boundaries:**
  - A valid frame, then a second valid frame 50 cycles later: the second frame's bytes are discarded with no pulses; a third frame after ≥100 idle cycles is accepted.
  - A byte coinciding with the timeout cycle is accepted.
  - Back-to-back `RX_Done_Sig` on consecutive cycles are both accepted.
- **Reset mid-frame:** assert `RSTn` low after 4 bytes.
  - Required: all outputs 0 immediately (asynchronously).
  - After release, a full valid frame produces `Frame_Done_Sig` with the correct data.
